sync_deframer: RTL and testbench
================================

Name: sync_deframer

Overview:
- Serial-to-byte stage directly downstream of the 8-bit LSB-first shift stage; consumes its qualified bit stream (one bit per enabled cycle).
- Hunts for a sync byte, then assembles fixed-length payload frames into bytes delivered over a valid/ready interface.
- Flywheels through a bounded number of missed sync bytes before dropping lock.
- Status flags feed control logic and the downstream byte consumer.

Parameters:
- SYNC_WORD, 8'h9F, sync byte value as assembled LSB-first.
- FRAME_LEN, 16, payload bytes per frame between sync bytes (legal range 1..255).
- MAX_MISS, 3, consecutive mismatched sync bytes before returning to HUNT (legal range 1..15).

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- bit_valid  in  1  qualifies bit_in for this cycle (the shift stage's enable).
- bit_in  in  1  serial data, LSB of each byte first.
- byte_ready  in  1  downstream accepts byte_data this cycle.
- byte_data  out  8  assembled payload byte.
- byte_valid  out  1  byte_data holds an unaccepted byte.
- frame_start  out  1  qualifies byte_data as first payload byte of a frame; valid only while byte_valid=1.
- locked  out  1  1 in PAYLOAD/VERIFY, 0 in HUNT.
- sync_loss  out  1  one-cycle pulse when lock is dropped.
- overflow  out  1  sticky: a completed byte was dropped; cleared only by reset.

Behaviour:
- One clock; reset is synchronous and active-high. All state is updated on the clk rising edge only when reset=0.
- Assembly:
  - On bit_valid=1: window <= {bit_in, window[7:1]}, so the first received bit lands in bit 0 after 8 shifts.
  - bit_valid=0: nothing shifts or counts.
- Reset values:
  - Outputs: byte_data=0, byte_valid=0, frame_start=0, locked=0, sync_loss=0, overflow=0.
  - Internal: window=0, state=HUNT, bit_cnt=0, byte_cnt=0, miss_cnt=0, hunt_fill=0.
  - Reset mid-byte or mid-frame discards all partial data.
- HUNT:
  - hunt_fill counts valid bits, saturating at 8.
  - Match requires hunt_fill>=7 before the current bit AND next window == SYNC_WORD. This prevents a false match on reset contents.
  - On match: -> PAYLOAD, bit_cnt=0, byte_cnt=0, miss_cnt=0, locked=1 from the next cycle.
  - The matched sync byte is never emitted.
- PAYLOAD:
  - bit_cnt counts 0..7.
  - On the valid bit with bit_cnt=7, the byte completes: the next window value is offered to the output register, bit_cnt wraps to 0, byte_cnt increments.
  - frame_start attaches when byte_cnt==0 at completion.
  - When the completed byte is number FRAME_LEN: byte_cnt=0, -> VERIFY.
- VERIFY:
  - Collects 8 bits; never emits them.
  - Match: miss_cnt=0, -> PAYLOAD.
  - Mismatch with miss_cnt+1 < MAX_MISS: miss_cnt+1, -> PAYLOAD. This is the flywheel; bits are treated as the sync position regardless.
  - Mismatch with miss_cnt+1 == MAX_MISS: -> HUNT, hunt_fill=0, locked=0 next cycle, sync_loss=1 for exactly one cycle.
  - After loss, hunting restarts fresh; the failing byte's bits do not count toward hunt_fill.
- Output handshake:
  - Transfer occurs when byte_valid & byte_ready.
  - byte_data and frame_start are held stable while byte_valid=1 and byte_ready=0.
  - Latency: byte_valid rises on the cycle after the completing bit's cycle.
- Output register load rules at byte completion:
  - Register empty, or transfer happening the same cycle: load new byte, byte_valid=1. No drop.
  - Register full with byte_ready=0: new byte dropped, register unchanged, overflow<=1.
  - No new byte and a transfer occurs: byte_valid<=0.
- Locking does not flush a pending output byte; it is still delivered.

Test Plan:
- Reset, then bits of 0x9F LSB-first (1,1,1,1,1,0,0,1) followed by FRAME_LEN=4 payload bytes 0x01,0x02,0x03,0x04 with byte_ready=1 -> locked rises the cycle after the 8th sync bit. Four bytes emitted in order, frame_start only on 0x01, each byte_valid one cycle after its 8th bit. No sync byte emitted.
- Locked, then sync 0x9F and bytes 0xA0..0xA3 with bit_valid toggling every other cycle -> same bytes. Gaps cause no extra counts.
- Locked with MAX_MISS=3; corrupt sync positions with 0x00 three times in a row -> frames after misses 1 and 2 still emitted. On the 3rd miss, sync_loss pulses once, locked=0, and subsequent bytes are not emitted until 0x9F is seen again.
- Hold byte_ready=0 across two completed bytes 0x11,0x22 -> byte_data stays 0x11 and overflow=1. Then byte_ready=1 on the exact cycle 0x33 completes -> 0x11 transfers, 0x33 loads, no additional drop.
- Immediately after reset, bit 1 on the first 7 valid cycles -> no lock. Assert reset mid-payload byte -> all outputs return to reset values the next cycle and a fresh sync is required.

Source files
------------

// File: rtl/sync_deframer_if.sv
// Bit-stream input and byte-stream output bundle of the sync deframer.
// The deframer takes master; the bit source and byte consumer side takes slave.
interface sync_deframer_if;
  logic       bit_valid;
  logic       bit_in;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_start;
  logic       locked;
  logic       sync_loss;
  logic       overflow;

  modport master (
    input  bit_valid, bit_in, byte_ready,
    output byte_data, byte_valid, frame_start, locked, sync_loss, overflow
  );

  modport slave (
    output bit_valid, bit_in, byte_ready,
    input  byte_data, byte_valid, frame_start, locked, sync_loss, overflow
  );
endinterface

// File: rtl/sync_deframer.sv
// Hunts for a sync byte in an LSB-first bit stream, then emits fixed-length payload
// frames as bytes over valid/ready, flywheeling through up to MAX_MISS-1 bad sync bytes.
module sync_deframer #(
  parameter logic [7:0]  SYNC_WORD = 8'h9F,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned MAX_MISS  = 3
) (
  input  logic           clk,
  input  logic           reset,
  sync_deframer_if.master bus
);

  typedef enum logic [1:0] {HUNT, PAYLOAD, VERIFY} state_e;

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);
  localparam logic [3:0] LAST_MISS = 4'(MAX_MISS - 1);

  state_e     state_q, state_d;
  logic [7:0] window_q, window_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;
  logic [3:0] hunt_fill_q, hunt_fill_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_valid_q, byte_valid_d;
  logic       frame_start_q, frame_start_d;
  logic       sync_loss_q, sync_loss_d;
  logic       overflow_q, overflow_d;

  logic       byte_done;
  logic       byte_first;
  logic       xfer;

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      window_q      <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      miss_cnt_q    <= '0;
      hunt_fill_q   <= '0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_loss_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of every other.
      state_q       <= state_d;
      window_q      <= window_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      hunt_fill_q   <= hunt_fill_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      sync_loss_q   <= sync_loss_d;
      overflow_q    <= overflow_d;
    end
  end

  // Next-state: shift window, count bits/bytes/misses, walk HUNT/PAYLOAD/VERIFY
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_d     = state_q;
    window_d    = window_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    hunt_fill_d = hunt_fill_q;
    byte_done   = 1'b0;
    byte_first  = 1'b0;
    if (bus.bit_valid) begin
      window_d = {bus.bit_in, window_q[7:1]};
      case (state_q)
        HUNT: begin
          // hunt_fill guard keeps stale window bits from forming a false sync
          if (hunt_fill_q >= 4'd7 && window_d == SYNC_WORD) begin
            state_d    = PAYLOAD;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            miss_cnt_d = '0;
          end else if (hunt_fill_q != 4'd8) begin
            hunt_fill_d = hunt_fill_q + 4'd1;
          end
        end
        PAYLOAD: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done  = 1'b1;
            byte_first = (byte_cnt_q == 8'd0);
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_d = '0;
              state_d    = VERIFY;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end
        end
        VERIFY: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (window_d == SYNC_WORD) begin
              miss_cnt_d = '0;
              state_d    = PAYLOAD;
            end else if (miss_cnt_q == LAST_MISS) begin
              miss_cnt_d  = '0;
              hunt_fill_d = '0;
              state_d     = HUNT;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
              state_d    = PAYLOAD;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign xfer = byte_valid_q & bus.byte_ready;

  // Outputs: single-entry byte register with drop-on-full, loss pulse
  always_comb begin
    byte_data_d   = byte_data_q;
    byte_valid_d  = byte_valid_q;
    frame_start_d = frame_start_q;
    overflow_d    = overflow_q;
    sync_loss_d   = (state_q == VERIFY) && (state_d == HUNT);
    if (byte_done) begin
      if (!byte_valid_q || xfer) begin
        byte_data_d   = window_d;
        frame_start_d = byte_first;
        byte_valid_d  = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (xfer) begin
      byte_valid_d = 1'b0;
    end
  end

  assign bus.byte_data   = byte_data_q;
  assign bus.byte_valid  = byte_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.locked      = (state_q != HUNT);
  assign bus.sync_loss   = sync_loss_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_sync_deframer.sv
// Directed bench for sync_deframer with FRAME_LEN=4, MAX_MISS=3: lock, gapped bits,
// flywheel and loss, backpressure/overflow, and reset behaviour.
module tb_sync_deframer;
  localparam logic [7:0] SYNC = 8'h9F;
  localparam int         FLEN = 4;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  sync_deframer_if bus();

  sync_deframer #(.SYNC_WORD(SYNC), .FRAME_LEN(FLEN), .MAX_MISS(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; each call returns just after the bit is taken.
  task automatic send_bit(input logic b, input bit gap);
    if (gap) begin
      bus.bit_valid = 1'b0;
      bus.bit_in    = ~b;
      @(posedge clk); #1;
    end
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    @(posedge clk); #1;
    bus.bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, input logic last_ready);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) bus.byte_ready = last_ready;
      send_bit(b[i], gap);
    end
  endtask

  task automatic do_reset();
    bus.bit_valid  = 1'b0;
    bus.bit_in     = 1'b0;
    bus.byte_ready = 1'b1;
    reset          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Payload frame base, base+1, ... ; each byte must be visible the cycle after its last bit.
  task automatic send_frame(input logic [7:0] base, input bit gap, input string name);
    logic [7:0] exp;
    for (int i = 0; i < FLEN; i++) begin
      exp = base + 8'(i);
      send_byte(exp, gap, 1'b1);
      vectors++;
      if (bus.byte_valid !== 1'b1 || bus.byte_data !== exp || bus.frame_start !== (i == 0)) begin
        miscompares++;
        $display("FAIL %s byte %0d: got valid=%b data=%h first=%b, want valid=1 data=%h first=%b",
                 name, i, bus.byte_valid, bus.byte_data, bus.frame_start, exp, (i == 0));
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bus.byte_data, bus.byte_valid, bus.frame_start, bus.locked, bus.sync_loss,
         bus.overflow} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_state: got data=%h valid=%b first=%b locked=%b loss=%b ovf=%b, want all 0",
               bus.byte_data, bus.byte_valid, bus.frame_start, bus.locked, bus.sync_loss, bus.overflow);
    end
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    vectors++;
    if (bus.locked !== 1'b0 || bus.byte_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL seven_ones: got locked=%b valid=%b, want 0 0", bus.locked, bus.byte_valid);
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 7; i++) send_bit(SYNC[i], 1'b0);
    vectors++;
    if (bus.locked !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_early: got locked=%b, want 0", bus.locked);
    end
    send_bit(SYNC[7], 1'b0);
    vectors++;
    if (bus.locked !== 1'b1 || bus.byte_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_rise: got locked=%b valid=%b, want 1 0", bus.locked, bus.byte_valid);
    end
    send_frame(8'h01, 1'b0, "lock");
    @(posedge clk); #1;
    vectors++;
    if (bus.byte_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_drain: got valid=%b, want 0", bus.byte_valid);
    end
  endtask

  task automatic test_gapped();
    send_byte(SYNC, 1'b1, 1'b1);
    vectors++;
    if (bus.locked !== 1'b1 || bus.byte_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_sync: got locked=%b valid=%b, want 1 0", bus.locked, bus.byte_valid);
    end
    send_frame(8'hA0, 1'b1, "gap");
  endtask

  task automatic test_flywheel();
    send_byte(8'h00, 1'b0, 1'b1);
    vectors++;
    if (bus.locked !== 1'b1 || bus.sync_loss !== 1'b0 || bus.byte_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL miss1: got locked=%b loss=%b valid=%b, want 1 0 0",
               bus.locked, bus.sync_loss, bus.byte_valid);
    end
    send_frame(8'hB0, 1'b0, "miss1_frame");
    send_byte(8'h00, 1'b0, 1'b1);
    vectors++;
    if (bus.locked !== 1'b1 || bus.sync_loss !== 1'b0) begin
      miscompares++;
      $display("FAIL miss2: got locked=%b loss=%b, want 1 0", bus.locked, bus.sync_loss);
    end
    send_frame(8'hC0, 1'b0, "miss2_frame");
    // 0xF8 misses, and its top five bits plus 0,0,1 would read as 0x9F with too few fresh bits
    send_byte(8'hF8, 1'b0, 1'b1);
    vectors++;
    if (bus.locked !== 1'b0 || bus.sync_loss !== 1'b1) begin
      miscompares++;
      $display("FAIL miss3_loss: got locked=%b loss=%b, want 0 1", bus.locked, bus.sync_loss);
    end
    send_bit(1'b0, 1'b0);
    vectors++;
    if (bus.sync_loss !== 1'b0) begin
      miscompares++;
      $display("FAIL loss_pulse: got loss=%b, want 0", bus.sync_loss);
    end
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    vectors++;
    if (bus.locked !== 1'b0) begin
      miscompares++;
      $display("FAIL hunt_guard: got locked=%b, want 0", bus.locked);
    end
    for (int i = 0; i < FLEN; i++) begin
      send_byte(8'hD0 + 8'(i), 1'b0, 1'b1);
      vectors++;
      if (bus.locked !== 1'b0 || bus.byte_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL hunt_byte %0d: got locked=%b valid=%b, want 0 0", i, bus.locked, bus.byte_valid);
      end
    end
    send_byte(SYNC, 1'b0, 1'b1);
    vectors++;
    if (bus.locked !== 1'b1 || bus.byte_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL relock: got locked=%b valid=%b, want 1 0", bus.locked, bus.byte_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.byte_ready = 1'b0;
    send_byte(8'h11, 1'b0, 1'b0);
    vectors++;
    if (bus.byte_valid !== 1'b1 || bus.byte_data !== 8'h11 || bus.frame_start !== 1'b1 ||
        bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_first: got valid=%b data=%h first=%b ovf=%b, want 1 11 1 0",
               bus.byte_valid, bus.byte_data, bus.frame_start, bus.overflow);
    end
    send_byte(8'h22, 1'b0, 1'b0);
    vectors++;
    if (bus.byte_valid !== 1'b1 || bus.byte_data !== 8'h11 || bus.frame_start !== 1'b1 ||
        bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_drop: got valid=%b data=%h first=%b ovf=%b, want 1 11 1 1",
               bus.byte_valid, bus.byte_data, bus.frame_start, bus.overflow);
    end
    send_byte(8'h33, 1'b0, 1'b1);
    vectors++;
    if (bus.byte_valid !== 1'b1 || bus.byte_data !== 8'h33 || bus.frame_start !== 1'b0 ||
        bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_same_cycle: got valid=%b data=%h first=%b ovf=%b, want 1 33 0 1",
               bus.byte_valid, bus.byte_data, bus.frame_start, bus.overflow);
    end
    send_byte(8'h44, 1'b0, 1'b1);
    vectors++;
    if (bus.byte_valid !== 1'b1 || bus.byte_data !== 8'h44) begin
      miscompares++;
      $display("FAIL bp_resume: got valid=%b data=%h, want 1 44", bus.byte_valid, bus.byte_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] partial;
    partial = 8'h3C;
    do_reset();
    bus.byte_ready = 1'b0;
    send_byte(SYNC, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    vectors++;
    if (bus.locked !== 1'b1 || bus.byte_valid !== 1'b1 || bus.byte_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL mid_setup: got locked=%b valid=%b data=%h, want 1 1 5a",
               bus.locked, bus.byte_valid, bus.byte_data);
    end
    for (int i = 0; i < 4; i++) send_bit(partial[i], 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({bus.byte_data, bus.byte_valid, bus.frame_start, bus.locked, bus.sync_loss,
         bus.overflow} !== 13'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got data=%h valid=%b first=%b locked=%b loss=%b ovf=%b, want all 0",
               bus.byte_data, bus.byte_valid, bus.frame_start, bus.locked, bus.sync_loss, bus.overflow);
    end
    reset = 1'b0;
    for (int i = 4; i < 8; i++) send_bit(partial[i], 1'b0);
    send_byte(8'h66, 1'b0, 1'b1);
    vectors++;
    if (bus.locked !== 1'b0 || bus.byte_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_nolock: got locked=%b valid=%b, want 0 0", bus.locked, bus.byte_valid);
    end
    send_byte(SYNC, 1'b0, 1'b1);
    send_byte(8'h77, 1'b0, 1'b1);
    vectors++;
    if (bus.locked !== 1'b1 || bus.byte_valid !== 1'b1 || bus.byte_data !== 8'h77 ||
        bus.frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_relock: got locked=%b valid=%b data=%h first=%b, want 1 1 77 1",
               bus.locked, bus.byte_valid, bus.byte_data, bus.frame_start);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_gapped();
    test_flywheel();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
